// File: rtl/doubly_pipeline.sv
// Doubly pipelined CORDIC: engine 1 vectors (a,b) onto +x and accumulates atan2(b,a),
// engine 2 applies the same micro-rotations to (p,q); fixed 18-cycle latency.
module doubly_pipeline #(
    parameter int N     = 31,
    parameter int ITER  = 16,
    parameter int GUARD = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic signed [N:0]   a,
    input  logic signed [N:0]   b,
    input  logic signed [N:0]   p,
    input  logic signed [N:0]   q,
    output logic signed [N:0]   pf,
    output logic signed [N:0]   qf,
    output logic signed [15:0]  output_angle
);

    // Fractional LSBs below the port LSB stop per-stage shift truncation from
    // accumulating into several LSBs of output error.
    localparam int FRAC = 12;
    localparam int IW   = N + 1 + GUARD + FRAC;
    localparam int PW   = IW + 18;

    localparam logic signed [31:0]   Z180  = 32'sd4608000;
    localparam logic signed [PW-1:0] INV_K = PW'(39797);
    localparam logic signed [PW-1:0] RND   = {{(PW-16-FRAC){1'b0}}, 1'b1, {(15+FRAC){1'b0}}};
    localparam logic signed [N:0]    SAT_HI = {1'b0, {N{1'b1}}};
    localparam logic signed [N:0]    SAT_LO = {1'b1, {N{1'b0}}};

    function automatic logic signed [31:0] atan_tab(input int unsigned i);
        case (i)
            0:  atan_tab = 32'sd1152000;
            1:  atan_tab = 32'sd680065;
            2:  atan_tab = 32'sd359328;
            3:  atan_tab = 32'sd182400;
            4:  atan_tab = 32'sd91554;
            5:  atan_tab = 32'sd45822;
            6:  atan_tab = 32'sd22916;
            7:  atan_tab = 32'sd11459;
            8:  atan_tab = 32'sd5730;
            9:  atan_tab = 32'sd2865;
            10: atan_tab = 32'sd1432;
            11: atan_tab = 32'sd716;
            12: atan_tab = 32'sd358;
            13: atan_tab = 32'sd179;
            14: atan_tab = 32'sd90;
            15: atan_tab = 32'sd45;
            16: atan_tab = 32'sd22;
            17: atan_tab = 32'sd11;
            18: atan_tab = 32'sd6;
            19: atan_tab = 32'sd3;
            20: atan_tab = 32'sd1;
            default: atan_tab = '0;
        endcase
    endfunction

    function automatic logic signed [N:0] sat(input logic signed [PW-1:0] v);
        if (v[PW-1:N] == '0 || v[PW-1:N] == '1)
            sat = v[N:0];
        else
            sat = v[PW-1] ? SAT_LO : SAT_HI;
    endfunction

    logic signed [IW-1:0] a_ext, b_ext, p_ext, q_ext;
    logic signed [IW-1:0] xs [0:ITER];
    logic signed [IW-1:0] ys [0:ITER];
    logic signed [IW-1:0] ps [0:ITER];
    logic signed [IW-1:0] qs [0:ITER];
    logic signed [31:0]   zs [0:ITER];
    logic signed [PW-1:0] pr, qr;

    always_comb begin
        a_ext = IW'(a) <<< FRAC;
        b_ext = IW'(b) <<< FRAC;
        p_ext = IW'(p) <<< FRAC;
        q_ext = IW'(q) <<< FRAC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i <= ITER; i++) begin
                xs[i] <= '0;
                ys[i] <= '0;
                ps[i] <= '0;
                qs[i] <= '0;
                zs[i] <= '0;
            end
        end else begin
            if (a[N]) begin
                xs[0] <= -a_ext;
                ys[0] <= -b_ext;
                ps[0] <= -p_ext;
                qs[0] <= -q_ext;
                zs[0] <= b[N] ? -Z180 : Z180;
            end else begin
                xs[0] <= a_ext;
                ys[0] <= b_ext;
                ps[0] <= p_ext;
                qs[0] <= q_ext;
                zs[0] <= '0;
            end
            // Engine 2 reuses engine 1's direction bit at every stage.
            for (int unsigned i = 0; i < ITER; i++) begin
                if (!ys[i][IW-1]) begin
                    xs[i+1] <= xs[i] + (ys[i] >>> i);
                    ys[i+1] <= ys[i] - (xs[i] >>> i);
                    ps[i+1] <= ps[i] + (qs[i] >>> i);
                    qs[i+1] <= qs[i] - (ps[i] >>> i);
                    zs[i+1] <= zs[i] + atan_tab(i);
                end else begin
                    xs[i+1] <= xs[i] - (ys[i] >>> i);
                    ys[i+1] <= ys[i] + (xs[i] >>> i);
                    ps[i+1] <= ps[i] - (qs[i] >>> i);
                    qs[i+1] <= qs[i] + (ps[i] >>> i);
                    zs[i+1] <= zs[i] - atan_tab(i);
                end
            end
        end
    end

    always_comb begin
        pr = (PW'(ps[ITER]) * INV_K + RND) >>> (16 + FRAC);
        qr = (PW'(qs[ITER]) * INV_K + RND) >>> (16 + FRAC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pf           <= '0;
            qf           <= '0;
            output_angle <= '0;
        end else begin
            pf           <= sat(pr);
            qf           <= sat(qr);
            output_angle <= 16'((zs[ITER] + 32'sd128) >>> 8);
        end
    end

endmodule

// File: tb/tb_doubly_pipeline.sv
// Directed-vector bench for doubly_pipeline: table of rotations with tolerances,
// plus pipelined-throughput and mid-stream reset sequences.
module tb_doubly_pipeline;

    logic               clk;
    logic               rst;
    logic signed [31:0] a, b, p, q;
    logic signed [31:0] pf, qf;
    logic signed [15:0] output_angle;

    int n_checks;
    int n_fail;

    typedef struct {
        logic signed [31:0] a, b, p, q;
        int                 epf, eqf, eang;
        int                 tol;
        bit                 chk_qf;
    } vec_t;

    vec_t tv [8];
    vec_t flush_v;

    doubly_pipeline #(.N(31), .ITER(16), .GUARD(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .a            (a),
        .b            (b),
        .p            (p),
        .q            (q),
        .pf           (pf),
        .qf           (qf),
        .output_angle (output_angle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp, input longint tol);
        n_checks++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d +-%0d", name, act, exp, tol);
        end
    endtask

    task automatic drive(input vec_t v);
        a = v.a;
        b = v.b;
        p = v.p;
        q = v.q;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".pf"}, longint'(pf), longint'(v.epf), longint'(v.tol));
        if (v.chk_qf)
            check({tag, ".qf"}, longint'(qf), longint'(v.eqf), longint'(v.tol));
        check({tag, ".angle"}, longint'(output_angle), longint'(v.eang), 2);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        a = '0; b = '0; p = '0; q = '0;

        tv[0] = '{32'sd1024,  32'sd768,   32'sd768,  32'sd1024,  1229,  358,   3687,   2, 1'b1};
        tv[1] = '{32'sd1024,  32'sd0,     32'sd300, -32'sd500,   300,  -500,   0,      2, 1'b1};
        tv[2] = '{32'sd0,     32'sd1024,  32'sd1000, 32'sd0,     0,    -1000,  9000,   2, 1'b1};
        tv[3] = '{-32'sd1024, 32'sd0,     32'sd500,  32'sd200,  -500,  -200,   18000,  2, 1'b1};
        tv[4] = '{32'sd1024, -32'sd1024,  32'sd1000, 32'sd0,     707,   707,  -4500,   2, 1'b1};
        tv[5] = '{-32'sd1024,-32'sd1024,  32'sd0,    32'sd1000, -707,  -707,  -13500,  2, 1'b1};
        tv[6] = '{32'sd1024,  32'sd1024,  32'sh7FFFFFFF, 32'sh7FFFFFFF, 2147483647, 0, 4500, 0, 1'b0};
        tv[7] = '{32'sd1024,  32'sd1024,  32'sh80000000, 32'sh80000000, int'(32'sh80000000), 0, 4500, 0, 1'b0};
        flush_v = '{32'sd1024, 32'sd0, 32'sd0, 32'sd0, 0, 0, 0, 2, 1'b1};

        // Reset held with random inputs: outputs stay zero.
        for (int c = 0; c < 3; c++) begin
            a = $urandom; b = $urandom; p = $urandom; q = $urandom;
            tick();
            check("reset.pf", longint'(pf), 0, 0);
            check("reset.qf", longint'(qf), 0, 0);
            check("reset.angle", longint'(output_angle), 0, 0);
        end
        rst = 1'b0;

        // Table: each vector held until it fills the pipe.
        for (int k = 0; k < 8; k++) begin
            drive(tv[k]);
            repeat (18) tick();
            check_vec($sformatf("vec%0d", k), tv[k]);
        end

        // Back-to-back inputs: each result lands exactly 18 edges after capture.
        drive(flush_v);
        repeat (18) tick();
        for (int c = 1; c <= 22; c++) begin
            if (c <= 4) drive(tv[c-1]);
            else        drive(flush_v);
            tick();
            if (c >= 18 && c <= 21)
                check_vec($sformatf("pipe%0d", c - 18), tv[c-18]);
            else if (c == 17 || c == 22)
                check_vec($sformatf("pipe_flush@%0d", c), flush_v);
        end

        // Mid-stream reset discards in-flight data.
        for (int c = 0; c < 4; c++) begin
            drive(tv[c]);
            tick();
        end
        rst = 1'b1;
        drive(tv[4]);
        tick();
        check("midrst.pf", longint'(pf), 0, 0);
        check("midrst.qf", longint'(qf), 0, 0);
        check("midrst.angle", longint'(output_angle), 0, 0);
        rst = 1'b0;
        drive(tv[4]);
        tick();
        drive(flush_v);
        for (int c = 2; c <= 18; c++) begin
            check($sformatf("postrst%0d.pf", c - 1), longint'(pf), 0, 0);
            check($sformatf("postrst%0d.qf", c - 1), longint'(qf), 0, 0);
            tick();
        end
        check_vec("postrst.vec4", tv[4]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
